// File: rtl/chacha_qr_host.sv
`default_nettype none
// ============================================================================
// Module   : chacha_qr_host
// Purpose  : Host-side sequencer for the ChaCha quarter-round core's byte-wide
//            register bus. Accepts a four-word state from a client, writes the
//            16 bytes into the core, pulses qr_en, waits QR_CYCLES cycles,
//            reads 16 bytes back and offers the four result words to the client.
// Ports    : clk, rst_n          clock, asynchronous active-low reset
//            in_valid/in_ready   input-state handshake (ready only in IDLE)
//            in_a..in_d          input words
//            out_valid/out_ready result handshake (valid only in DONE)
//            out_a..out_d        registered result words
//            bus_data            write byte to core (ui_in)
//            bus_ctrl            {wr_en, qr_en, 2'b00, addr[3:0]} (uio_in)
//            bus_rdata           read byte from core (uo_out), comb. on addr
//            busy                high in every state except IDLE
// Revision : 1.0 - initial release
// ============================================================================
module chacha_qr_host #(
  parameter int QR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  input  logic [31:0] in_c,
  input  logic [31:0] in_d,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_a,
  output logic [31:0] out_b,
  output logic [31:0] out_c,
  output logic [31:0] out_d,
  output logic [7:0]  bus_data,
  output logic [7:0]  bus_ctrl,
  input  logic [7:0]  bus_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_KICK  = 3'd2,
    S_WAIT  = 3'd3,
    S_READ  = 3'd4,
    S_DONE  = 3'd5
  } state_e;

  localparam logic [7:0] WAIT_LAST = 8'(QR_CYCLES - 1);

  state_e       state_q, state_d;
  logic [7:0]   cnt_q, cnt_d;
  // Byte k of both vectors lives at bits [8k+7:8k]: word k[3:2], lane k[1:0].
  logic [127:0] shadow_q, shadow_d;
  logic [127:0] result_q, result_d;
  logic [7:0]   bus_data_q, bus_data_d;
  logic [7:0]   bus_ctrl_q, bus_ctrl_d;
  logic         in_ready_q, in_ready_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;

  // Next-state logic. All bus/handshake outputs are derived from the *next*
  // state and counter so that the registered outputs line up with the state
  // they belong to (WRITE byte 0 is on the bus in the first WRITE cycle).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    result_d = result_q;

    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          shadow_d = {in_d, in_c, in_b, in_a};
          cnt_d    = 8'd0;
          state_d  = S_WRITE;
        end
      end
      S_WRITE: begin
        if (cnt_q == 8'd15) begin
          cnt_d   = 8'd0;
          state_d = S_KICK;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_KICK: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == WAIT_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_READ;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_READ: begin
        // bus_rdata reflects the address presented during this cycle.
        result_d[{cnt_q[3:0], 3'b000} +: 8] = bus_rdata;
        if (cnt_q == 8'd15) begin
          cnt_d   = 8'd0;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase

    bus_data_d = 8'd0;
    bus_ctrl_d = 8'd0;
    case (state_d)
      S_WRITE: begin
        bus_data_d = shadow_d[{cnt_d[3:0], 3'b000} +: 8];
        bus_ctrl_d = {1'b1, 1'b0, 2'b00, cnt_d[3:0]};
      end
      S_KICK:  bus_ctrl_d = 8'h40;
      S_READ:  bus_ctrl_d = {1'b0, 1'b0, 2'b00, cnt_d[3:0]};
      default: begin
        bus_data_d = 8'd0;
        bus_ctrl_d = 8'd0;
      end
    endcase

    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      shadow_q    <= 128'd0;
      result_q    <= 128'd0;
      bus_data_q  <= 8'd0;
      bus_ctrl_q  <= 8'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shadow_q    <= shadow_d;
      result_q    <= result_d;
      bus_data_q  <= bus_data_d;
      bus_ctrl_q  <= bus_ctrl_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign bus_data  = bus_data_q;
  assign bus_ctrl  = bus_ctrl_q;
  // Result bytes only change during READ, so out_* are stable throughout DONE.
  assign out_a     = result_q[31:0];
  assign out_b     = result_q[63:32];
  assign out_c     = result_q[95:64];
  assign out_d     = result_q[127:96];

endmodule
`default_nettype wire

// File: tb/tb_chacha_qr_host.sv
`default_nettype none
// ============================================================================
// Module   : tb_chacha_qr_host
// Purpose  : Self-checking bench for chacha_qr_host. Two instances (QR_CYCLES
//            of 1 and 4) share the client inputs; each drives its own core
//            model. Expected words come from a word-level quarter-round model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_chacha_qr_host;

  localparam int Q1 = 1;
  localparam int Q4 = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;
  logic        out_ready = 1'b1;
  logic        qr_mode = 1'b0;

  always #5 clk = ~clk;

  logic        in_ready1, out_valid1, busy1;
  logic [31:0] out_a1, out_b1, out_c1, out_d1;
  logic [7:0]  data1, ctrl1, rdata1;
  logic        in_ready4, out_valid4, busy4, in_valid4;
  logic [31:0] out_a4, out_b4, out_c4, out_d4;
  logic [7:0]  data4, ctrl4, rdata4;

  // The Q=4 instance only starts when the Q=1 instance does, keeping them aligned.
  assign in_valid4 = in_valid & in_ready1;

  chacha_qr_host #(.QR_CYCLES(Q1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid1), .out_ready(out_ready),
    .out_a(out_a1), .out_b(out_b1), .out_c(out_c1), .out_d(out_d1),
    .bus_data(data1), .bus_ctrl(ctrl1), .bus_rdata(rdata1), .busy(busy1));

  chacha_qr_host #(.QR_CYCLES(Q4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
    .out_valid(out_valid4), .out_ready(1'b1),
    .out_a(out_a4), .out_b(out_b4), .out_c(out_c4), .out_d(out_d4),
    .bus_data(data4), .bus_ctrl(ctrl4), .bus_rdata(rdata4), .busy(busy4));

  // ---------------- reference quarter round (RFC 8439) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [127:0] qr(input logic [127:0] s);
    logic [31:0] a, b, c, d;
    a = s[31:0]; b = s[63:32]; c = s[95:64]; d = s[127:96];
    a = a + b; d = d ^ a; d = rotl(d, 16);
    c = c + d; b = b ^ c; b = rotl(b, 12);
    a = a + b; d = d ^ a; d = rotl(d, 8);
    c = c + d; b = b ^ c; b = rotl(b, 7);
    return {d, c, b, a};
  endfunction

  function automatic logic [127:0] expect_out(input logic [127:0] s, input logic m);
    return m ? qr(s) : s;
  endfunction

  // ---------------- core models (byte k at bits [8k+7:8k]) ----------------
  logic [127:0] core1 = '0, core4 = '0;
  always @(posedge clk) begin
    if (ctrl1[7]) core1[{ctrl1[3:0], 3'b000} +: 8] <= data1;
    else if (ctrl1[6] && qr_mode) core1 <= qr(core1);
    if (ctrl4[7]) core4[{ctrl4[3:0], 3'b000} +: 8] <= data4;
    else if (ctrl4[6] && qr_mode) core4 <= qr(core4);
  end
  assign rdata1 = core1[{ctrl1[3:0], 3'b000} +: 8];
  assign rdata4 = core4[{ctrl4[3:0], 3'b000} +: 8];

  // ---------------- monitors ----------------
  int           cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic         ov1_prev = 1'b0, ov4_prev = 1'b0, overlap = 1'b0;
  int           qr_total1 = 0;
  int           rise1[$], rise4[$];
  logic [127:0] res1[$], res4[$];
  always @(negedge clk) begin
    ov1_prev <= out_valid1;
    ov4_prev <= out_valid4;
    if (out_valid1 && !ov1_prev) begin
      rise1.push_back(cyc);
      res1.push_back({out_d1, out_c1, out_b1, out_a1});
    end
    if (out_valid4 && !ov4_prev) begin
      rise4.push_back(cyc);
      res4.push_back({out_d4, out_c4, out_b4, out_a4});
    end
    if ((ctrl1[7] && ctrl1[6]) || (ctrl4[7] && ctrl4[6])) overlap <= 1'b1;
    if (ctrl1[6]) qr_total1 <= qr_total1 + 1;
  end

  int checks = 0;
  int errors = 0;
  int rd1 = 0, rd4 = 0;

  // ---------------- helpers ----------------
  task automatic start_txn(input logic [127:0] s, output int e);
    int n = 0;
    while (!(in_ready1 && in_ready4) && n < 500) begin
      @(posedge clk); #1; n++;
    end
    if (!(in_ready1 && in_ready4)) begin
      checks++; errors++;
      $display("FAIL start_txn: in_ready timeout got %b%b required 11", in_ready1, in_ready4);
    end
    {in_d, in_c, in_b, in_a} = s;
    in_valid = 1'b1;
    @(posedge clk); #1;
    e = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_res1(output logic [127:0] r, output int rc);
    int n = 0;
    while (rd1 >= res1.size() && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (rd1 >= res1.size()) begin
      checks++; errors++;
      $display("FAIL wait_result1: out_valid timeout got 0 required 1");
      r = '0; rc = -1;
    end else begin
      r = res1[rd1]; rc = rise1[rd1]; rd1++;
    end
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    checks++;
    if ({in_ready1, out_valid1, busy1, data1, ctrl1} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
      errors++;
      $display("FAIL reset_ctrl: got %b%b%b %h %h required 100 00 00",
               in_ready1, out_valid1, busy1, data1, ctrl1);
    end
    checks++;
    if ({out_d1, out_c1, out_b1, out_a1} !== 128'd0) begin
      errors++;
      $display("FAIL reset_out: got %h required 0", {out_d1, out_c1, out_b1, out_a1});
    end
  endtask

  task automatic test_write_order();
    int e;
    logic [127:0] s, r;
    int rc;
    qr_mode = 1'b0;
    s = {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100};
    start_txn(s, e);
    for (int k = 0; k < 16; k++) begin
      checks++;
      if ({ctrl1, data1} !== {8'h80 | 8'(k), 8'(k)}) begin
        errors++;
        $display("FAIL write_order k=%0d: got ctrl %h data %h required ctrl %h data %h",
                 k, ctrl1, data1, 8'h80 | 8'(k), 8'(k));
      end
      @(posedge clk); #1;
    end
    checks++;
    if ({ctrl1, data1} !== 16'h4000) begin
      errors++;
      $display("FAIL kick_bus: got ctrl %h data %h required 40 00", ctrl1, data1);
    end
    wait_res1(r, rc);
    checks++;
    if (r !== s) begin
      errors++;
      $display("FAIL write_loopback: got %h required %h", r, s);
    end
  endtask

  task automatic test_loopback();
    logic [127:0] s, r;
    int e, rc;
    qr_mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = (i == 0) ? {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111} : rnd128();
      start_txn(s, e);
      wait_res1(r, rc);
      checks++;
      if (r !== s) begin
        errors++;
        $display("FAIL loopback[%0d]: got %h required %h", i, r, s);
      end
      // out_valid appears in cycle E+34+Q, i.e. 33+Q edges after E.
      checks++;
      if (rc !== e + (34 + Q1) - 1) begin
        errors++;
        $display("FAIL loopback_latency[%0d]: got %0d required %0d", i, rc - e + 1, 34 + Q1);
      end
    end
  endtask

  task automatic test_reset_midwrite();
    int e, base;
    logic [127:0] s;
    qr_mode = 1'b0;
    s = rnd128();
    start_txn(s, e);
    repeat (7) begin @(posedge clk); #1; end
    checks++;
    if (ctrl1 !== 8'h87) begin
      errors++;
      $display("FAIL midwrite_addr: got %h required 87", ctrl1);
    end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({data1, ctrl1, in_ready1, out_valid1, busy1} !== {16'h0000, 3'b100}) begin
      errors++;
      $display("FAIL midwrite_reset: got data %h ctrl %h rdy %b ov %b busy %b required 00 00 1 0 0",
               data1, ctrl1, in_ready1, out_valid1, busy1);
    end
    checks++;
    if ({out_d1, out_c1, out_b1, out_a1} !== 128'd0) begin
      errors++;
      $display("FAIL midwrite_out_clear: got %h required 0", {out_d1, out_c1, out_b1, out_a1});
    end
    #2 rst_n = 1'b1;
    base = res1.size();
    repeat (80) begin @(posedge clk); #1; end
    checks++;
    if (res1.size() !== base) begin
      errors++;
      $display("FAIL no_spurious_valid: got %0d results required 0", res1.size() - base);
    end
    rd1 = res1.size();
    rd4 = res4.size();
  endtask

  task automatic test_quarter_round();
    logic [127:0] s, r, exp;
    int e, rc, q0;
    qr_mode = 1'b1;
    s = {32'h01234567, 32'h9b8d6f43, 32'h01020304, 32'h11111111};
    q0 = qr_total1;
    start_txn(s, e);
    wait_res1(r, rc);
    checks++;
    if (r !== {32'h5881c4bb, 32'h4581472e, 32'hcb1cf8ce, 32'hea2a92f4}) begin
      errors++;
      $display("FAIL qr_rfc_vector: got %h required 5881c4bb4581472ecb1cf8ceea2a92f4", r);
    end
    checks++;
    if (qr_total1 - q0 !== 1) begin
      errors++;
      $display("FAIL qr_pulse_width: got %0d cycles required 1", qr_total1 - q0);
    end
    for (int i = 0; i < 4; i++) begin
      s = rnd128();
      exp = expect_out(s, 1'b1);
      start_txn(s, e);
      wait_res1(r, rc);
      checks++;
      if (r !== exp) begin
        errors++;
        $display("FAIL qr_random[%0d]: got %h required %h", i, r, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] s, s2, r, snap;
    int e, rc;
    qr_mode = 1'b1;
    out_ready = 1'b0;
    s = rnd128();
    start_txn(s, e);
    wait_res1(r, rc);
    snap = expect_out(s, 1'b1);
    s2 = rnd128();
    {in_d, in_c, in_b, in_a} = s2;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid1, in_ready1, busy1, out_d1, out_c1, out_b1, out_a1} !== {3'b101, snap}) begin
        errors++;
        $display("FAIL backpressure_hold[%0d]: got ov%b rdy%b busy%b %h required ov1 rdy0 busy1 %h",
                 i, out_valid1, in_ready1, busy1, {out_d1, out_c1, out_b1, out_a1}, snap);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid1, in_ready1, busy1} !== 3'b010) begin
      errors++;
      $display("FAIL release_idle: got ov%b rdy%b busy%b required ov0 rdy1 busy0",
               out_valid1, in_ready1, busy1);
    end
    @(posedge clk); #1;
    e = cyc;
    in_valid = 1'b0;
    checks++;
    if ({busy1, ctrl1, data1} !== {1'b1, 8'h80, s2[7:0]}) begin
      errors++;
      $display("FAIL accept_after_done: got busy%b ctrl %h data %h required busy1 ctrl 80 data %h",
               busy1, ctrl1, data1, s2[7:0]);
    end
    wait_res1(r, rc);
    checks++;
    if (r !== expect_out(s2, 1'b1)) begin
      errors++;
      $display("FAIL backpressure_next: got %h required %h", r, expect_out(s2, 1'b1));
    end
  endtask

  task automatic test_back_to_back();
    int es[3];
    logic [127:0] ex[3];
    logic [127:0] r;
    int k = 0, n = 0, rc;
    qr_mode = 1'b1;
    out_ready = 1'b1;
    {in_d, in_c, in_b, in_a} = rnd128();
    in_valid = 1'b1;
    while (k < 3 && n < 400) begin
      if (in_ready1) begin
        ex[k] = expect_out({in_d, in_c, in_b, in_a}, 1'b1);
        @(posedge clk); #1;
        es[k] = cyc;
        k++;
        {in_d, in_c, in_b, in_a} = rnd128();
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (k !== 3) begin
      errors++;
      $display("FAIL b2b_accepts: got %0d required 3", k);
    end else begin
      for (int i = 0; i < 3; i++) begin
        wait_res1(r, rc);
        checks++;
        if (r !== ex[i] || rc !== es[i] + (34 + Q1) - 1) begin
          errors++;
          $display("FAIL b2b_result[%0d]: got %h at %0d required %h at %0d",
                   i, r, rc - es[i] + 1, ex[i], 34 + Q1);
        end
        if (i > 0) begin
          checks++;
          if (es[i] - es[i-1] !== 35 + Q1) begin
            errors++;
            $display("FAIL b2b_period[%0d]: got %0d required %0d", i, es[i] - es[i-1], 35 + Q1);
          end
        end
      end
    end
  endtask

  task automatic test_qr_cycles4();
    logic [127:0] s, r;
    int e, n = 0, rc;
    qr_mode = 1'b1;
    s = rnd128();
    start_txn(s, e);
    rd4 = rise4.size();
    while (rd4 >= res4.size() && n < 300) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (rd4 >= res4.size()) begin
      errors++;
      $display("FAIL q4_timeout: got no out_valid required out_valid");
    end else begin
      r = res4[rd4]; rc = rise4[rd4];
      if (r !== expect_out(s, 1'b1) || rc !== e + (34 + Q4) - 1) begin
        errors++;
        $display("FAIL q4_result: got %h latency %0d required %h latency %0d",
                 r, rc - e + 1, expect_out(s, 1'b1), 34 + Q4);
      end
    end
    checks++;
    if (overlap !== 1'b0) begin
      errors++;
      $display("FAIL wr_qr_overlap: got 1 required 0");
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_write_order();
    test_loopback();
    test_reset_midwrite();
    test_quarter_round();
    test_backpressure();
    test_back_to_back();
    test_qr_cycles4();
    repeat (5) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/chacha_qr_host.md
# chacha_qr_host

Host-side sequencer for the ChaCha quarter-round core's byte-wide register bus. It accepts a four-word state (a, b, c, d) over a valid/ready handshake and writes the 16 bytes into the core. It then pulses the quarter-round enable, waits a programmable number of cycles, reads the 16 result bytes back and presents the four result words over a second valid/ready handshake. It sits between a word-level client and the core's `ui_in`/`uio_in`/`uo_out` pins.

## Interface
Parameters:
- QR_CYCLES, default 1: cycles spent in WAIT after the qr_en pulse; legal range 1..255.

Ports:
- clk  in  1  Clock.
- rst_n  in  1  Reset, asynchronous, active-low.
- in_valid  in  1  Client offers a state.
- in_ready  out  1  High only in IDLE.
- in_a, in_b, in_c, in_d  in  32 each  Input words.
- out_valid  out  1  Result words valid (DONE).
- out_ready  in  1  Client accepts the result.
- out_a, out_b, out_c, out_d  out  32 each  Result words; registered; held stable while out_valid=1.
- bus_data  out  8  Write byte to the core; drives `ui_in`.
- bus_ctrl  out  8  Core control byte; drives `uio_in`.
  - [7]: wr_en.
  - [6]: qr_en.
  - [5:4]: 0.
  - [3:0]: addr.
- bus_rdata  in  8  Core read byte; from `uo_out`, combinational on addr.
- busy  out  1  High in every state except IDLE.

## Operation
- Core address map:
  - addr[3:2] selects the word: 0=a, 1=b, 2=c, 3=d.
  - addr[1:0] selects the byte lane, 0 = bits [7:0] up to 3 = bits [31:24].
- State machine: IDLE -> WRITE -> KICK -> WAIT -> READ -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid at a rising edge, the four input words are latched into an internal 128-bit shadow register and the FSM moves to WRITE.
- WRITE, 16 cycles, k=0..15:
  - addr=k, wr_en=1, qr_en=0.
  - bus_data = byte lane k[1:0] of word k[3:2] taken from the shadow register.
- KICK, 1 cycle: wr_en=0, qr_en=1, addr=0, bus_data=0.
- WAIT, QR_CYCLES cycles: wr_en=qr_en=0, addr=0, bus_data=0.
- READ, 16 cycles, k=0..15:
  - addr=k, wr_en=qr_en=0, bus_data=0.
  - At the end of the cycle, bus_rdata is captured into byte k of the result register.
- DONE:
  - out_valid=1 and the bus is idle.
  - When out_ready=1 at a rising edge, out_valid falls and the FSM returns to IDLE.
- All bus outputs are registered.
- wr_en and qr_en are never high in the same cycle.
- in_valid is ignored outside IDLE.
- A new state cannot be accepted in the same cycle a result is accepted.

## Timing
- Reset (asynchronous, rst_n=0):
  - FSM goes to IDLE.
  - in_ready=1 after release; all other outputs 0.
  - out_a..out_d=0 and the shadow register is cleared.
  - Any transaction in flight is aborted and nothing is emitted.
  - The core resets synchronously, so its contents are undefined until it is rewritten.
- Let edge E be the in_valid & in_ready edge:
  - WRITE cycles: E+1 .. E+16.
  - KICK: E+17.
  - WAIT: E+18 .. E+17+QR_CYCLES.
  - READ: the next 16 cycles.
  - out_valid rises 34+QR_CYCLES cycles after E.
- Back-to-back throughput: one state per 35+QR_CYCLES cycles when out_ready is held at 1 (the DONE and IDLE cycles are included).
- out_ready held low: DONE holds indefinitely with out_* stable; busy=1.
- busy falls on the same edge that out_valid falls.

## Test plan
- Reset check: assert rst_n=0 mid-WRITE (k=7) -> next cycle all bus outputs=0, in_ready=1, out_valid=0; after release, no spurious out_valid.
- Write ordering: in_a=0x03020100, in_b=0x07060504, in_c=0x0B0A0908, in_d=0x0F0E0D0C -> bus_data equals addr on each of the 16 write cycles, wr_en=1 throughout, addr 0..15 in order.
- Loopback, using a core model with no quarter-round (qr_en ignored): in = {0x11111111, 0x01020304, 0x9b8d6f43, 0x01234567} -> out equals in; out_valid at E+35 with QR_CYCLES=1.
- Quarter round, using the RFC 8439 §2.1.1 model, same input -> out_a=0xea2a92f4, out_b=0xcb1cf8ce, out_c=0x4581472e, out_d=0x5881c4bb; qr_en high for exactly 1 cycle.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 -> out_* stable, in_ready=0; out_ready=1 -> IDLE next cycle, new state accepted one cycle later.
- QR_CYCLES=4: latency from E to out_valid = 38 cycles; qr_en and wr_en never high together across the whole run.
